// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-master data-memory port arbiter.
// Holds the state encoding, requester IDs and the legal read-latency range.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Combinational two-way round-robin pick: on a tie the requester that was
// not served last wins, otherwise the single active requester is chosen.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last;
    end else if (req1) begin
      grant_id = REQ_AUX;
    end else begin
      grant_id = REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between the CPU RAM
// window (requester 0) and an auxiliary copy engine (requester 1).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_d_out,
  input  logic [DW-1:0] mem_d_in,
  output logic          busy,
  output logic          gnt_id
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be within 1..3");
  end

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t        state_reg, state_next;
  logic          last_reg;
  logic          gnt_reg;
  logic          we_reg;
  logic [1:0]    cnt_reg;
  logic [AW-1:0] mem_a_reg;
  logic [DW-1:0] mem_d_reg;
  logic [DW-1:0] rdata0_reg, rdata1_reg;

  logic          grant_valid;
  logic          grant_id;
  logic          load_grant;
  logic          sample_rd;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  arb_rr2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last        (last_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we    = (grant_id == REQ_AUX) ? we1    : we0;
  assign sel_addr  = (grant_id == REQ_AUX) ? addr1  : addr0;
  assign sel_wdata = (grant_id == REQ_AUX) ? wdata1 : wdata0;

  always_comb begin
    state_next = state_reg;
    load_grant = 1'b0;
    sample_rd  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          load_grant = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = we_reg ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        // cnt_reg reaches 1 on the cycle where mem_d_in carries the read data
        if (cnt_reg == 2'd1) begin
          sample_rd  = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg  <= ST_IDLE;
      last_reg   <= REQ_AUX;
      gnt_reg    <= REQ_CPU;
      we_reg     <= 1'b0;
      cnt_reg    <= 2'd0;
      mem_a_reg  <= '0;
      mem_d_reg  <= '0;
      rdata0_reg <= '0;
      rdata1_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load_grant) begin
        gnt_reg   <= grant_id;
        last_reg  <= grant_id;
        we_reg    <= sel_we;
        mem_a_reg <= sel_addr;
        mem_d_reg <= sel_wdata;
      end
      if (state_reg == ST_ACCESS) begin
        cnt_reg <= LAT;
      end else if (state_reg == ST_WAIT) begin
        cnt_reg <= cnt_reg - 2'd1;
      end
      if (sample_rd) begin
        if (gnt_reg == REQ_AUX) begin
          rdata1_reg <= mem_d_in;
        end else begin
          rdata0_reg <= mem_d_in;
        end
      end
    end
  end

  // Strobes decode straight from state registers so clr drops them at once.
  assign mem_we    = (state_reg == ST_ACCESS) && we_reg;
  assign ack0      = (state_reg == ST_ACK) && (gnt_reg == REQ_CPU);
  assign ack1      = (state_reg == ST_ACK) && (gnt_reg == REQ_AUX);
  assign busy      = (state_reg != ST_IDLE);
  assign gnt_id    = gnt_reg;
  assign mem_a     = mem_a_reg;
  assign mem_d_out = mem_d_reg;
  assign rdata0    = rdata0_reg;
  assign rdata1    = rdata1_reg;

endmodule
